fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Program-counter and fetch controller that sequences the team's combinational instruction ROM (IW-bit address in, DW-bit machine code out).
- Selects one of four program entry points on a start handshake and steps the PC each cycle, handling absolute and relative branches from the decoder.
- Holds on stall, stops on halt and reports completion with a done handshake.
- Sits between the testbench/top-level handshake and the decoder/datapath.

Parameters:
IW, 10, PC / ROM address width
DW, 9, machine code width
OW, 8, signed relative branch offset width (OW <= IW)
CW, 16, cycle counter width
ENTRY0, 0, program 0 start address
ENTRY1, 256, program 1 start address
ENTRY2, 512, program 2 start address
ENTRY3, 768, program 3 start address

Ports:
Clk  input  1  clock; all state changes on rising edge
Reset_n  input  1  synchronous active-low reset
Start  input  1  begin program selected by ProgSel
ProgSel  input  2  entry point select (0..3 -> ENTRY0..ENTRY3)
Halt  input  1  decoder: current instruction is halt
Stall  input  1  datapath: hold current instruction
BranchAbs  input  1  take absolute branch to AbsTarget
AbsTarget  input  IW  absolute branch target
BranchRel  input  1  take PC-relative branch
RelOffset  input  OW  signed two's-complement offset
InstIn  input  DW  machine code from ROM
InstAddress  output  IW  PC, drives ROM address
InstOut  output  DW  instruction to decoder
InstValid  output  1  InstOut is a live instruction
Busy  output  1  program running
Done  output  1  program finished
CycleCount  output  CW  cycles spent in RUN for current/last program

Behaviour:
- States: IDLE, RUN, DONE, held in one registered state variable.
- Reset (Reset_n low at a rising edge, any state, including mid-RUN): next state IDLE, PC=0, CycleCount=0. Reset has priority over all other inputs.
- Outputs are combinational from state:
  - InstValid = Busy = (state==RUN).
  - Done = (state==DONE).
  - InstOut = InstIn when RUN, else all zeros.
  - InstAddress = PC at all times.
- IDLE:
  - Start=1 -> PC <= ENTRY[ProgSel], CycleCount <= 0, go RUN.
  - Start=0 -> stay; PC holds.
- RUN, one update per cycle, priority Halt > Stall > BranchAbs > BranchRel > sequential:
  - Halt: go DONE, PC holds (points at the halt instruction).
  - Stall: PC holds.
  - BranchAbs: PC <= AbsTarget.
  - BranchRel: PC <= PC + sign-extended RelOffset, modulo 2^IW.
  - Otherwise: PC <= PC + 1, modulo 2^IW (PC = 2^IW-1 wraps to 0).
  - CycleCount increments every RUN cycle, including stalls and the halt cycle. It saturates at 2^CW-1 and never wraps.
  - Start is ignored while in RUN; ProgSel is sampled only on the start edge.
- DONE:
  - PC and CycleCount hold; Done=1 stays high indefinitely.
  - Start=1 -> restart exactly as from IDLE (reload entry, clear CycleCount, go RUN). Done drops the following cycle.
- Latency:
  - First instruction address is on InstAddress the cycle after Start is sampled.
  - A branch taken in cycle N shows its target in cycle N+1. No delay slots.
- Simultaneous events: Halt with a branch -> halt wins, branch discarded. Stall with a branch -> branch discarded. The decoder must re-present the branch when the stall clears.

Test Plan:
- Reset then start: hold Reset_n=0 two cycles -> InstAddress=0, Busy=0, Done=0, CycleCount=0, InstOut=0. Then Start=1, ProgSel=2 -> next cycle InstAddress=512, InstValid=1. Three free cycles -> 513, 514, 515.
- Branches: in RUN at PC=300, BranchRel=1, RelOffset=8'hFC -> PC=296. Then BranchAbs=1, AbsTarget=700 with BranchRel=1 on the same cycle -> PC=700 (abs wins).
- Stall and wrap: ProgSel=3, force BranchAbs to 1022, then two sequential cycles -> 1023, 0. Stall=1 for 3 cycles at PC=0 -> PC stays 0, CycleCount advances by 3.
- Halt/done handshake: Halt=1 at PC=5 with BranchAbs=1 -> state DONE, InstAddress=5, Done=1, InstValid=0, InstOut=0. Done holds for 10 cycles. Start=1, ProgSel=1 -> InstAddress=256, Done=0, CycleCount restarts from 0.
- Reset mid-operation: Reset_n=0 for one edge while in RUN at PC=77 -> next cycle IDLE, PC=0, CycleCount=0. Start high in the same cycle as reset is ignored.
- Counter saturation (CW=4 override): run 20 cycles without halt -> CycleCount reaches 15 and stays 15.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// Handshake and ROM/decoder bus of the fetch sequencer.
// The master side drives control and ROM data; the slave side is the sequencer.
interface fetch_sequencer_if #(
    parameter int IW = 10,
    parameter int DW = 9,
    parameter int OW = 8,
    parameter int CW = 16
);
    logic          start;
    logic [1:0]    prog_sel;
    logic          halt;
    logic          stall;
    logic          branch_abs;
    logic [IW-1:0] abs_target;
    logic          branch_rel;
    logic [OW-1:0] rel_offset;
    logic [DW-1:0] inst_in;
    logic [IW-1:0] inst_address;
    logic [DW-1:0] inst_out;
    logic          inst_valid;
    logic          busy;
    logic          done;
    logic [CW-1:0] cycle_count;

    modport master (
        output start, prog_sel, halt, stall, branch_abs, abs_target,
               branch_rel, rel_offset, inst_in,
        input  inst_address, inst_out, inst_valid, busy, done, cycle_count
    );

    modport slave (
        input  start, prog_sel, halt, stall, branch_abs, abs_target,
               branch_rel, rel_offset, inst_in,
        output inst_address, inst_out, inst_valid, busy, done, cycle_count
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: selects an entry point on start,
// steps/branches the PC while running, and reports completion on halt.
module fetch_sequencer #(
    parameter int IW     = 10,
    parameter int DW     = 9,
    parameter int OW     = 8,
    parameter int CW     = 16,
    parameter int ENTRY0 = 0,
    parameter int ENTRY1 = 256,
    parameter int ENTRY2 = 512,
    parameter int ENTRY3 = 768
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    fetch_sequencer_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [IW-1:0] r_pc;
    logic [CW-1:0] r_cycles;

    logic [IW-1:0] w_entry;
    logic [IW-1:0] w_rel_ext;
    logic [CW-1:0] w_cycles_inc;
    logic          w_run;

    // Entry point lookup for the program being started.
    always_comb begin
        w_entry = IW'(ENTRY0);
        case (bus.prog_sel)
            2'd0:    w_entry = IW'(ENTRY0);
            2'd1:    w_entry = IW'(ENTRY1);
            2'd2:    w_entry = IW'(ENTRY2);
            2'd3:    w_entry = IW'(ENTRY3);
            default: w_entry = IW'(ENTRY0);
        endcase
    end

    // Signed size cast sign-extends the offset; the add then wraps modulo 2^IW.
    assign w_rel_ext    = IW'($signed(bus.rel_offset));
    assign w_cycles_inc = (r_cycles == {CW{1'b1}}) ? r_cycles : (r_cycles + CW'(1));
    assign w_run        = (r_state == ST_RUN);

    // State, PC and cycle counter update; reset dominates every other input.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state  <= ST_IDLE;
            r_pc     <= {IW{1'b0}};
            r_cycles <= {CW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state  <= ST_RUN;
                        r_pc     <= w_entry;
                        r_cycles <= {CW{1'b0}};
                    end else begin
                        r_state  <= r_state;
                        r_pc     <= r_pc;
                        r_cycles <= r_cycles;
                    end
                end
                ST_RUN: begin
                    r_cycles <= w_cycles_inc;
                    if (bus.halt) begin
                        r_state <= ST_DONE;
                        r_pc    <= r_pc;
                    end else if (bus.stall) begin
                        r_state <= ST_RUN;
                        r_pc    <= r_pc;
                    end else if (bus.branch_abs) begin
                        r_state <= ST_RUN;
                        r_pc    <= bus.abs_target;
                    end else if (bus.branch_rel) begin
                        r_state <= ST_RUN;
                        r_pc    <= r_pc + w_rel_ext;
                    end else begin
                        r_state <= ST_RUN;
                        r_pc    <= r_pc + IW'(1);
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_pc     <= {IW{1'b0}};
                    r_cycles <= {CW{1'b0}};
                end
            endcase
        end
    end

    assign bus.inst_address = r_pc;
    assign bus.inst_valid   = w_run;
    assign bus.busy         = w_run;
    assign bus.done         = (r_state == ST_DONE);
    assign bus.inst_out     = w_run ? bus.inst_in : {DW{1'b0}};
    assign bus.cycle_count  = r_cycles;
endmodule
